fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 59 +++++
 tb/tb_fetch_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer with jumps, taken-branch prediction, mispredict recovery and an address-limit halt
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] MAX_INSADDR = 32'hffff_fff8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic [1:0]  if_jop,
  input  logic [25:0] if_imm,
  input  logic        id_jr,
  input  logic [31:0] id_rv,
  input  logic        id_br_valid,
  input  logic        id_br_taken,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        flush_if,
  output logic        halted,
  output logic [15:0] mispred_cnt
);
  typedef enum logic [1:0] {RUN, PRED, HALT} state_t;
  state_t state;
  logic [31:0] bpc, pc4, tgt;
  logic mis, br, jmp, over;
  always_comb begin
    pc4 = pc + 32'd4;
    mis = state == PRED && id_br_valid && !id_br_taken;
    br = if_jop == 2'b11;
    jmp = if_jop == 2'b01 || if_jop == 2'b10;
    tgt = id_jr ? id_rv
        : mis ? bpc + 32'd4
        : jmp ? {pc4[31:28], if_imm, 2'b00}
        : br ? pc4 + {{14{if_imm[15]}}, if_imm[15:0], 2'b00}
        : pc4;
    over = tgt > MAX_INSADDR;
    npc = !rstn ? RESET_PC : state == HALT ? pc : tgt;
    flush_if = rstn && !stall && state != HALT && (id_jr || mis);
  end
  // a redirect from ID makes the IF-stage jump class wrong-path, so only plain fetches may predict
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc <= RESET_PC;
      bpc <= '0;
      state <= RUN;
      halted <= 1'b0;
      mispred_cnt <= '0;
    end else if (!stall && state != HALT) begin
      if (mis && !id_jr && mispred_cnt != 16'hffff) mispred_cnt <= mispred_cnt + 16'd1;
      if (over) begin
        state <= HALT;
        halted <= 1'b1;
      end else begin
        pc <= tgt;
        state <= (!id_jr && !mis && br) ? PRED : RUN;
        if (!id_jr && !mis && br) bpc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors for fetch_ctrl, plus a low-limit instance for the halt path
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic stall = 1'b0;
  logic [1:0] if_jop = '0;
  logic [25:0] if_imm = '0;
  logic id_jr = 1'b0;
  logic [31:0] id_rv = '0;
  logic id_br_valid = 1'b0;
  logic id_br_taken = 1'b0;
  logic [31:0] pc, npc, h_pc, h_npc;
  logic flush_if, halted, h_flush, h_halted;
  logic [15:0] mispred_cnt, h_cnt;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rstn(rstn), .stall(stall), .if_jop(if_jop), .if_imm(if_imm),
    .id_jr(id_jr), .id_rv(id_rv), .id_br_valid(id_br_valid), .id_br_taken(id_br_taken),
    .pc(pc), .npc(npc), .flush_if(flush_if), .halted(halted), .mispred_cnt(mispred_cnt)
  );

  fetch_ctrl #(.MAX_INSADDR(32'h0000_3008)) dut_h (
    .clk(clk), .rstn(rstn), .stall(1'b0), .if_jop(2'b00), .if_imm(26'd0),
    .id_jr(1'b0), .id_rv(32'd0), .id_br_valid(1'b0), .id_br_taken(1'b0),
    .pc(h_pc), .npc(h_npc), .flush_if(h_flush), .halted(h_halted), .mispred_cnt(h_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; if_jop = '0; if_imm = '0; id_jr = 1'b0; id_rv = '0;
    id_br_valid = 1'b0; id_br_taken = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_pc", pc, 32'h3000);
    check("rst_npc", npc, 32'h3000);
    check("rst_flush", {31'd0, flush_if}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cnt", {16'd0, mispred_cnt}, 32'd0);
    rstn = 1'b1;
    #1;
    check("seq0", pc, 32'h3000);
    check("seq0_npc", npc, 32'h3004);
    tick(); check("seq1", pc, 32'h3004);
    tick(); check("seq2", pc, 32'h3008);
    tick(); check("seq3", pc, 32'h300c);
    check("h_pc", h_pc, 32'h3008);
    check("h_halted", {31'd0, h_halted}, 32'd1);
    check("h_npc", h_npc, 32'h3008);
    repeat (3) tick();
    check("h_hold_pc", h_pc, 32'h3008);
    check("h_hold_halted", {31'd0, h_halted}, 32'd1);
    check("h_hold_flush", {31'd0, h_flush}, 32'd0);

    // predicted branch, then mispredict
    do_reset();
    tick(); check("br_at", pc, 32'h3004);
    if_jop = 2'b11; if_imm = 26'h3; #1;
    check("br_npc", npc, 32'h3014);
    tick(); idle();
    check("br_pc", pc, 32'h3014);
    id_br_valid = 1'b1; #1;
    check("mis_flush", {31'd0, flush_if}, 32'd1);
    check("mis_npc", npc, 32'h3008);
    tick();
    check("mis_pc", pc, 32'h3008);
    check("mis_cnt", {16'd0, mispred_cnt}, 32'd1);
    check("run_noflush", {31'd0, flush_if}, 32'd0);
    idle();

    // stalled JR, then release
    stall = 1'b1; id_jr = 1'b1; id_rv = 32'h4000; #1;
    check("stall_flush0", {31'd0, flush_if}, 32'd0);
    tick(); check("stall_pc1", pc, 32'h3008);
    tick(); check("stall_pc2", pc, 32'h3008);
    check("stall_flush2", {31'd0, flush_if}, 32'd0);
    stall = 1'b0; #1;
    check("jr_flush", {31'd0, flush_if}, 32'd1);
    check("jr_npc", npc, 32'h4000);
    tick(); idle();
    check("jr_pc", pc, 32'h4000);

    // jump, then back-to-back predicted branches with confirm
    do_reset();
    if_jop = 2'b01; if_imm = 26'h0000c10; #1;
    check("j_npc", npc, 32'h3040);
    tick(); check("j_pc", pc, 32'h3040);
    if_jop = 2'b11; if_imm = 26'h2;
    tick(); check("br2_pc", pc, 32'h304c);
    id_br_valid = 1'b1; id_br_taken = 1'b1; if_jop = 2'b11; if_imm = 26'h1; #1;
    check("conf_flush", {31'd0, flush_if}, 32'd0);
    check("conf_npc", npc, 32'h3054);
    tick(); idle();
    check("conf_pc", pc, 32'h3054);
    id_br_valid = 1'b1; #1;
    check("rebpc_npc", npc, 32'h3050);
    check("rebpc_flush", {31'd0, flush_if}, 32'd1);
    tick(); idle();
    check("rebpc_cnt", {16'd0, mispred_cnt}, 32'd1);

    // absent ID branch confirms; a later bare ID flag is ignored in RUN
    if_jop = 2'b11; tick(); idle();
    tick();
    id_br_valid = 1'b1; #1;
    check("implicit_conf", {31'd0, flush_if}, 32'd0);
    idle();

    for (int i = 0; i < 4; i++) begin
      if_jop = 2'b11; tick(); idle();
      id_br_valid = 1'b1; tick(); idle();
    end
    check("cnt5", {16'd0, mispred_cnt}, 32'd5);
    if_jop = 2'b11; tick(); idle();
    #3;
    id_jr = 1'b1; id_br_valid = 1'b1;
    rstn = 1'b0; #1;
    check("arst_pc", pc, 32'h3000);
    check("arst_cnt", {16'd0, mispred_cnt}, 32'd0);
    check("arst_halted", {31'd0, halted}, 32'd0);
    check("arst_npc", npc, 32'h3000);
    check("arst_flush", {31'd0, flush_if}, 32'd0);
    idle();
    rstn = 1'b1;
    id_br_valid = 1'b1; #1;
    check("arst_run", {31'd0, flush_if}, 32'd0);
    idle();

    // JR while a prediction is outstanding drops it without counting
    if_jop = 2'b11; tick(); idle();
    id_jr = 1'b1; id_rv = 32'h3100; id_br_valid = 1'b1; #1;
    check("jrpred_npc", npc, 32'h3100);
    tick(); idle();
    check("jrpred_pc", pc, 32'h3100);
    check("jrpred_cnt", {16'd0, mispred_cnt}, 32'd0);
    id_br_valid = 1'b1; #1;
    check("jrpred_run", {31'd0, flush_if}, 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
